// File: rtl/pc_core_n2k_ingress_filter.sv
// Store-and-forward ingress filter for the n2k AXI4-Stream path.
// Packets whose masked tdest matches this core are buffered. A packet is forwarded only
// after it is complete. Mismatched or oversized packets are discarded whole. Saturating
// statistics count accepted and dropped packets.
module pc_core_n2k_ingress_filter #(
  parameter int unsigned C_TDATA_WIDTH = 512,
  parameter int unsigned C_TDEST_WIDTH = 16,
  parameter int unsigned C_DEPTH       = 64,
  parameter int unsigned C_CNT_WIDTH   = 32
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  input  logic [C_TDEST_WIDTH-1:0]   cfg_dest,
  input  logic [C_TDEST_WIDTH-1:0]   cfg_dest_mask,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [C_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_TDEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_TDEST_WIDTH-1:0]   m_axis_tdest,
  output logic [C_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [C_CNT_WIDTH-1:0]     stat_pkt_accepted,
  output logic [C_CNT_WIDTH-1:0]     stat_pkt_dropped
);

  localparam int unsigned KeepW = C_TDATA_WIDTH / 8;
  localparam int unsigned AddrW = $clog2(C_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned EntW  = C_TDATA_WIDTH + KeepW + C_TDEST_WIDTH + 1;

  typedef enum logic [0:0] {StAccept, StDrop} state_e;

  // Buffer storage, entry = {tdata, tkeep, tdest, tlast}
  logic [EntW-1:0] mem [C_DEPTH];

  state_e          state_q, state_d;
  logic            sop_q, sop_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] wr_commit_q, wr_commit_d;
  // Delayed copy of wr_commit seen by egress; sets the tlast-to-first-beat latency
  logic [PtrW-1:0] commit_egr_q;
  // rd_ptr frees space only on a downstream handshake; rd_fetch runs one ahead
  // while the output register holds a beat.
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] rd_fetch_q, rd_fetch_d;
  logic            out_valid_q, out_valid_d;
  logic [EntW-1:0] out_entry_q, out_entry_d;
  logic [C_CNT_WIDTH-1:0] acc_cnt_q, drop_cnt_q;

  logic            s_hs;
  logic            full;
  logic            dest_match;
  logic            mem_we;
  logic            inc_acc;
  logic            inc_drop;
  logic            avail;
  logic            load;
  logic            pop;

  assign s_axis_tready = ~areset;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign full          = (wr_ptr_q - rd_ptr_q) == PtrW'(C_DEPTH);
  assign dest_match    = ((s_axis_tdest ^ cfg_dest) & cfg_dest_mask) == '0;

  // Ingress FSM next state, speculative write pointer and commit logic
  always_comb begin
    state_d     = state_q;
    sop_d       = sop_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    mem_we      = 1'b0;
    inc_acc     = 1'b0;
    inc_drop    = 1'b0;
    if (s_hs) begin
      case (state_q)
        StAccept: begin
          if (sop_q && !dest_match) begin
            if (s_axis_tlast) inc_drop = 1'b1;
            else              state_d  = StDrop;
          end else if (full) begin
            // Overflow: discard everything written for this packet
            wr_ptr_d = wr_commit_q;
            sop_d    = 1'b1;
            if (s_axis_tlast) inc_drop = 1'b1;
            else              state_d  = StDrop;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            sop_d    = s_axis_tlast;
            if (s_axis_tlast) begin
              wr_commit_d = wr_ptr_q + PtrW'(1);
              inc_acc     = 1'b1;
            end
          end
        end
        StDrop: begin
          if (s_axis_tlast) begin
            inc_drop = 1'b1;
            state_d  = StAccept;
            sop_d    = 1'b1;
          end
        end
        default: begin
          state_d = StAccept;
          sop_d   = 1'b1;
        end
      endcase
    end
  end

  // Ingress state registers
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= StAccept;
      sop_q        <= 1'b1;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      commit_egr_q <= '0;
    end else begin
      state_q      <= state_d;
      sop_q        <= sop_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      commit_egr_q <= wr_commit_q;
    end
  end

  // Buffer write port
  always_ff @(posedge ap_clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AddrW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tdest, s_axis_tlast};
    end
  end

  assign avail = rd_fetch_q != commit_egr_q;
  assign pop   = out_valid_q & m_axis_tready;
  assign load  = avail & (~out_valid_q | m_axis_tready);

  // Egress FWFT: refill the output register whenever it empties or is consumed
  always_comb begin
    out_valid_d = load | (out_valid_q & ~m_axis_tready);
    rd_fetch_d  = load ? rd_fetch_q + PtrW'(1) : rd_fetch_q;
    rd_ptr_d    = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    out_entry_d = load ? mem[rd_fetch_q[AddrW-1:0]] : out_entry_q;
  end

  // Egress registers
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      rd_fetch_q  <= '0;
      rd_ptr_q    <= '0;
      out_entry_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rd_fetch_q  <= rd_fetch_d;
      rd_ptr_q    <= rd_ptr_d;
      out_entry_q <= out_entry_d;
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tdest, m_axis_tlast} = out_entry_q;

  // Saturating packet statistics
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (inc_acc && (acc_cnt_q != '1))   acc_cnt_q  <= acc_cnt_q + C_CNT_WIDTH'(1);
      if (inc_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + C_CNT_WIDTH'(1);
    end
  end

  assign stat_pkt_accepted = acc_cnt_q;
  assign stat_pkt_dropped  = drop_cnt_q;

endmodule

// File: tb/tb_pc_core_n2k_ingress_filter.sv
// Directed bench for pc_core_n2k_ingress_filter with small buffer and counters.
module tb_pc_core_n2k_ingress_filter;

  localparam int unsigned DW = 32;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned TW = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          areset;
  logic [TW-1:0] cfg_dest;
  logic [TW-1:0] cfg_mask;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [TW-1:0] s_tdest;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [TW-1:0] m_tdest;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [CW-1:0] acc;
  logic [CW-1:0] drop;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rx_data[$];
  logic [TW-1:0] rx_dest[$];
  logic [KW-1:0] rx_keep[$];
  logic          rx_last[$];

  pc_core_n2k_ingress_filter #(
    .C_TDATA_WIDTH(DW),
    .C_TDEST_WIDTH(TW),
    .C_DEPTH      (DEPTH),
    .C_CNT_WIDTH  (CW)
  ) dut (
    .ap_clk           (clk),
    .areset           (areset),
    .cfg_dest         (cfg_dest),
    .cfg_dest_mask    (cfg_mask),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_tdata     (s_tdata),
    .s_axis_tdest     (s_tdest),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tlast     (s_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tdest     (m_tdest),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tlast     (m_tlast),
    .stat_pkt_accepted(acc),
    .stat_pkt_dropped (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture egress handshakes; m_tready only changes just after posedge
  always @(negedge clk) begin
    if (!areset && m_tvalid && m_tready) begin
      rx_data.push_back(m_tdata);
      rx_dest.push_back(m_tdest);
      rx_keep.push_back(m_tkeep);
      rx_last.push_back(m_tlast);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [TW-1:0] dest,
                      input logic [KW-1:0] keep, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tdest  = dest;
    s_tkeep  = keep;
    s_tlast  = last;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Last beat carries keep=0x7 so keep passthrough is visible
  task automatic send_pkt(input logic [DW-1:0] base, input logic [TW-1:0] dest, input int n);
    for (int i = 0; i < n; i++) begin
      send(base + DW'(i), dest, (i == n - 1) ? 4'h7 : 4'hF, i == n - 1);
    end
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_dest.delete();
    rx_keep.delete();
    rx_last.delete();
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    clear_rx();
  endtask

  initial begin
    areset   = 1'b1;
    cfg_dest = 16'h0003;
    cfg_mask = 16'hFFFF;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tdest  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_drop", drop, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", s_tready, 1);

    // 1: matching 4-beat packet, first beat valid two edges after tlast
    m_tready = 1'b1;
    send_pkt(32'hA000_0000, 16'h0003, 4);
    @(negedge clk);
    @(negedge clk);
    chk("t1_lat_k1", m_tvalid, 0);
    @(negedge clk);
    chk("t1_lat_k2", m_tvalid, 1);
    chk("t1_first_data", m_tdata, 32'hA000_0000);
    idle(6);
    chk("t1_rx_count", rx_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_data%0d", i), (rx_data.size() > i) ? rx_data[i] : 'x,
          32'hA000_0000 + i);
      chk($sformatf("t1_last%0d", i), (rx_last.size() > i) ? rx_last[i] : 'x, (i == 3));
    end
    chk("t1_keep0", (rx_keep.size() > 0) ? rx_keep[0] : 'x, 4'hF);
    chk("t1_keep3", (rx_keep.size() > 3) ? rx_keep[3] : 'x, 4'h7);
    chk("t1_dest0", (rx_dest.size() > 0) ? rx_dest[0] : 'x, 16'h0003);
    chk("t1_acc", acc, 1);
    chk("t1_drop", drop, 0);

    // 2: mismatched destination dropped whole
    do_reset();
    m_tready = 1'b1;
    send_pkt(32'hB000_0000, 16'h0005, 3);
    chk("t2_s_tready", s_tready, 1);
    idle(5);
    chk("t2_m_tvalid", m_tvalid, 0);
    chk("t2_rx_count", rx_data.size(), 0);
    chk("t2_acc", acc, 0);
    chk("t2_drop", drop, 1);

    // 3: oversized packet dropped, following packet intact
    do_reset();
    m_tready = 1'b1;
    send_pkt(32'hC000_0000, 16'h0003, 10);
    send_pkt(32'hD000_0000, 16'h0003, 3);
    idle(8);
    chk("t3_drop", drop, 1);
    chk("t3_acc", acc, 1);
    chk("t3_rx_count", rx_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_data%0d", i), (rx_data.size() > i) ? rx_data[i] : 'x,
          32'hD000_0000 + i);
    end
    chk("t3_last2", (rx_last.size() > 2) ? rx_last[2] : 'x, 1);

    // 4: buffer full under backpressure, output held stable
    do_reset();
    m_tready = 1'b0;
    send_pkt(32'hE000_0000, 16'h0003, 4);
    send_pkt(32'hE000_0010, 16'h0003, 4);
    send_pkt(32'hE000_0020, 16'h0003, 1);
    idle(4);
    chk("t4_hold_valid", m_tvalid, 1);
    chk("t4_hold_data_a", m_tdata, 32'hE000_0000);
    idle(3);
    chk("t4_hold_data_b", m_tdata, 32'hE000_0000);
    chk("t4_drop", drop, 1);
    chk("t4_acc", acc, 2);
    m_tready = 1'b1;
    idle(12);
    chk("t4_rx_count", rx_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_data%0d", i), (rx_data.size() > i) ? rx_data[i] : 'x,
          (i < 4) ? 32'hE000_0000 + i : 32'hE000_0010 + (i - 4));
    end

    // 5: reset mid-packet discards buffered and partial packets
    do_reset();
    m_tready = 1'b0;
    send_pkt(32'hF000_0000, 16'h0003, 2);
    send(32'hF000_0010, 16'h0003, 4'hF, 1'b0);
    send(32'hF000_0011, 16'h0003, 4'hF, 1'b0);
    areset = 1'b1;
    @(negedge clk);
    chk("t5_rst_s_tready", s_tready, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    chk("t5_m_tvalid", m_tvalid, 0);
    chk("t5_acc", acc, 0);
    chk("t5_drop", drop, 0);
    clear_rx();
    m_tready = 1'b1;
    send_pkt(32'hF000_0020, 16'h0003, 2);
    idle(6);
    chk("t5_rx_count", rx_data.size(), 2);
    chk("t5_data0", (rx_data.size() > 0) ? rx_data[0] : 'x, 32'hF000_0020);
    chk("t5_data1", (rx_data.size() > 1) ? rx_data[1] : 'x, 32'hF000_0021);
    chk("t5_last1", (rx_last.size() > 1) ? rx_last[1] : 'x, 1);
    chk("t5_acc_after", acc, 1);

    // 6: masked compare and counter saturation
    do_reset();
    cfg_dest = 16'h1200;
    cfg_mask = 16'hFF00;
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(32'h0000_0060 + i, 16'h3400, 4'hF, 1'b1);
    end
    idle(2);
    chk("t6_drop_sat", drop, 4'hF);
    chk("t6_acc0", acc, 0);
    chk("t6_rx_none", rx_data.size(), 0);
    send(32'h1234_5678, 16'h12AB, 4'hF, 1'b1);
    idle(6);
    chk("t6_acc1", acc, 1);
    chk("t6_drop_hold", drop, 4'hF);
    chk("t6_rx_count", rx_data.size(), 1);
    chk("t6_data", (rx_data.size() > 0) ? rx_data[0] : 'x, 32'h1234_5678);
    chk("t6_dest", (rx_dest.size() > 0) ? rx_dest[0] : 'x, 16'h12AB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
